regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Write-side master for the 32x32 register file. Merges two write-back sources onto the single
//  RegWrite/Write_reg/Write_data port. The single-cycle ALU result has priority. Long-latency
//  results (mul/div/load) arrive through a valid/ready handshake and are buffered in a FIFO.
//  Keeps a 32-bit pending scoreboard of destinations with long ops in flight, for hazard stall.
// PARAMETERS
//  FIFO_DEPTH  4   long-unit result buffer entries; power of 2, >=2
//  DATA_W      32  write-data width
//  ADDR_W      5   register address width
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous active-high reset
//  alu_valid   in   1        ALU result present this cycle
//  alu_reg     in   ADDR_W   ALU destination register
//  alu_data    in   DATA_W   ALU result
//  alu_stall   out  1        ALU write refused this cycle; upstream must hold off
//  lu_valid    in   1        long-unit result offered
//  lu_ready    out  1        FIFO can accept (transfer = lu_valid & lu_ready)
//  lu_reg      in   ADDR_W   long-unit destination register
//  lu_data     in   DATA_W   long-unit result
//  iss_valid   in   1        long op issued this cycle
//  iss_reg     in   ADDR_W   destination register of the issued long op
//  pending     out  32       scoreboard; bit r=1 while a long write to r is outstanding
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  RegWrite    out  1        register-file write enable (registered)
//  Write_reg   out  ADDR_W   register-file write address (registered)
//  Write_data  out  DATA_W   register-file write data (registered)
// BEHAVIOUR
//  - Reset: RegWrite=0, Write_reg=0, Write_data=0, pending=0, FIFO empty (fifo_count=0).
//    lu_ready=1 and alu_stall=0 in the first cycle after reset.
//  - Reset mid-operation discards all buffered entries and clears every pending bit.
//  - alu_stall = (fifo_count==FIFO_DEPTH). lu_ready = (fifo_count<FIFO_DEPTH).
//    Both are combinational from the registered count.
//  - Arbitration, evaluated each cycle; the result is registered onto the write port (1-cycle latency):
//    1. If alu_valid & !alu_stall & alu_reg!=0: write the ALU value. The FIFO does not pop.
//    2. Otherwise, if the FIFO is non-empty: pop the head and write it.
//    3. Otherwise: RegWrite<=0. Write_reg and Write_data hold their previous values.
//  - alu_valid while alu_stall=1 is a protocol violation. The ALU data is dropped and the FIFO head drains.
//  - A write to r0 is never emitted. An ALU r0 write acts as idle and lets the FIFO drain.
//    An lu_reg==0 transfer is accepted (handshake completes) but is not pushed.
//  - Push and pop in the same cycle: count is unchanged, and the FIFO keeps in-order data.
//    The write/read pointers wrap modulo FIFO_DEPTH.
//  - Long-unit results retire strictly in acceptance order. ALU writes may overtake them.
//  - pending[r] is set at the clock edge after iss_valid & iss_reg==r, for r!=0.
//    pending[r] is cleared at the edge where a FIFO pop of destination r is registered to the write port.
//    Set and clear of the same r in the same cycle: set wins.
//    pending[0] is always 0. ALU writes never change pending.
// CONFIGURATION
//  WB_FWD_EN defined: adds these ports:
//    fwd_addr_1, fwd_addr_2       in   ADDR_W
//    fwd_hit_1,  fwd_hit_2        out  1
//    fwd_data_1, fwd_data_2       out  DATA_W
//    fwd_hit_n = RegWrite & Write_reg==fwd_addr_n & fwd_addr_n!=0 (combinational).
//    fwd_data_n = Write_data when hit, else 0.
//    This lets decode bypass a write the register file has not yet committed.
//  WB_FWD_EN undefined: the ports and logic are absent. Readers see the value one cycle after the write.
// TESTING
//  1. rst held 2 cycles -> RegWrite=0, pending=0, fifo_count=0, lu_ready=1, alu_stall=0.
//  2. alu_valid, alu_reg=3, alu_data=0xDEADBEEF -> next cycle RegWrite=1, Write_reg=3,
//     Write_data=0xDEADBEEF.
//  3. iss r5; lu push r5=0x55 while alu_valid holds (r7) each cycle -> pending[5] stays 1.
//     ALU writes r7 each cycle. After the ALU goes idle, r5=0x55 is written and pending[5]
//     clears on the same edge.
//  4. Push 4 lu results with the ALU busy -> fifo_count=4, lu_ready=0, alu_stall=1.
//     On the next edge the head drains, count=3, and alu_stall drops.
//  5. Same-cycle iss_reg=9 and FIFO pop of r9 -> pending[9]=1 afterwards.
//     Also: alu_reg=0 with FIFO non-empty -> the FIFO head is written, never r0.
//  6. WB_FWD_EN: RegWrite=1, Write_reg=12, Write_data=0x1234, fwd_addr_1=12, fwd_addr_2=0
//     -> fwd_hit_1=1, fwd_data_1=0x1234, fwd_hit_2=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file: ALU results have priority, long-unit results queue
// in an in-order FIFO, and a pending scoreboard tracks in-flight long ops. Optional WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_valid,
  input  logic [ADDR_W-1:0]               alu_reg,
  input  logic [DATA_W-1:0]               alu_data,
  output logic                            alu_stall,
  input  logic                            lu_valid,
  output logic                            lu_ready,
  input  logic [ADDR_W-1:0]               lu_reg,
  input  logic [DATA_W-1:0]               lu_data,
  input  logic                            iss_valid,
  input  logic [ADDR_W-1:0]               iss_reg,
  output logic [31:0]                     pending,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            RegWrite,
  output logic [ADDR_W-1:0]               Write_reg,
  output logic [DATA_W-1:0]               Write_data
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]               fwd_addr_1,
  input  logic [ADDR_W-1:0]               fwd_addr_2,
  output logic                            fwd_hit_1,
  output logic                            fwd_hit_2,
  output logic [DATA_W-1:0]               fwd_data_1,
  output logic [DATA_W-1:0]               fwd_data_2
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);

  logic [ADDR_W-1:0] mem_reg_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       pending_q, pending_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic alu_win, push, pop, accept;

  always_comb begin
    alu_stall = (count_q == FullCnt);
    lu_ready  = (count_q != FullCnt);
    accept    = lu_valid & lu_ready;
    // r0 destinations complete the handshake but never enter the queue
    push      = accept & (lu_reg != '0);
    alu_win   = alu_valid & ~alu_stall & (alu_reg != '0);
    pop       = ~alu_win & (count_q != '0);
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    pending_d  = pending_q;

    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (alu_win) begin
      regwrite_d = 1'b1;
      wreg_d     = alu_reg;
      wdata_d    = alu_data;
    end else if (pop) begin
      regwrite_d = 1'b1;
      wreg_d     = mem_reg_q[rptr_q];
      wdata_d    = mem_data_q[rptr_q];
    end

    // Clear before set so a same-cycle issue to the retiring register stays pending
    if (pop) pending_d[32'(mem_reg_q[rptr_q])] = 1'b0;
    if (iss_valid) pending_d[32'(iss_reg)] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg_q[wptr_q]  <= lu_reg;
      mem_data_q[wptr_q] <= lu_data;
    end
  end

  assign pending    = pending_q;
  assign fifo_count = count_q;
  assign RegWrite   = regwrite_q;
  assign Write_reg  = wreg_q;
  assign Write_data = wdata_q;

`ifdef WB_FWD_EN
  // Bypass the value being committed this cycle to decode readers
  always_comb begin
    fwd_hit_1  = regwrite_q & (wreg_q == fwd_addr_1) & (fwd_addr_1 != '0);
    fwd_hit_2  = regwrite_q & (wreg_q == fwd_addr_2) & (fwd_addr_2 != '0);
    fwd_data_1 = fwd_hit_1 ? wdata_q : '0;
    fwd_data_2 = fwd_hit_2 ? wdata_q : '0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; honours WB_FWD_EN when defined.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        iss_valid;
  logic [4:0]  iss_reg;
  logic [31:0] pending;
  logic [2:0]  fifo_count;
  logic        RegWrite;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_addr_1, fwd_addr_2;
  logic        fwd_hit_1, fwd_hit_2;
  logic [31:0] fwd_data_1, fwd_data_2;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.FIFO_DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_reg     (lu_reg),
    .lu_data    (lu_data),
    .iss_valid  (iss_valid),
    .iss_reg    (iss_reg),
    .pending    (pending),
    .fifo_count (fifo_count),
    .RegWrite   (RegWrite),
    .Write_reg  (Write_reg),
    .Write_data (Write_data)
`ifdef WB_FWD_EN
    ,
    .fwd_addr_1 (fwd_addr_1),
    .fwd_addr_2 (fwd_addr_2),
    .fwd_hit_1  (fwd_hit_1),
    .fwd_hit_2  (fwd_hit_2),
    .fwd_data_1 (fwd_data_1),
    .fwd_data_2 (fwd_data_2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] r,
                          input logic [31:0] d);
    check({tag, ".we"}, 32'(RegWrite), 32'(we));
    check({tag, ".reg"}, 32'(Write_reg), 32'(r));
    check({tag, ".data"}, Write_data, d);
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    lu_valid = 1'b0; lu_reg = '0; lu_data = '0; iss_valid = 1'b0; iss_reg = '0;
`ifdef WB_FWD_EN
    fwd_addr_1 = '0; fwd_addr_2 = '0;
`endif

    // Reset
    tick(); tick();
    rst = 1'b0;
    check_wr("rst", 1'b0, 5'd0, 32'h0);
    check("rst.pending", pending, 32'h0);
    check("rst.count", 32'(fifo_count), 32'd0);
    check("rst.lu_ready", 32'(lu_ready), 32'd1);
    check("rst.alu_stall", 32'(alu_stall), 32'd0);

    // Simple ALU write
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hDEADBEEF;
    tick();
    check_wr("alu3", 1'b1, 5'd3, 32'hDEADBEEF);

    // Long op on r5 held behind a busy ALU writing r7
    alu_reg = 5'd7; alu_data = 32'h77; iss_valid = 1'b1; iss_reg = 5'd5;
    tick();
    iss_valid = 1'b0;
    check("t3.pend_set", pending, 32'h20);
    check_wr("t3.alu7a", 1'b1, 5'd7, 32'h77);
    lu_valid = 1'b1; lu_reg = 5'd5; lu_data = 32'h55;
    tick();
    lu_valid = 1'b0;
    check("t3.count1", 32'(fifo_count), 32'd1);
    check_wr("t3.alu7b", 1'b1, 5'd7, 32'h77);
    tick();
    check("t3.pend_hold", pending, 32'h20);
    check_wr("t3.alu7c", 1'b1, 5'd7, 32'h77);
    alu_valid = 1'b0;
    tick();
    check_wr("t3.lu5", 1'b1, 5'd5, 32'h55);
    check("t3.pend_clr", pending, 32'h0);
    check("t3.count0", 32'(fifo_count), 32'd0);

    // Fill the FIFO with the ALU busy, then watch it drain in order
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h99;
    for (int i = 0; i < 4; i++) begin
      lu_valid = 1'b1; lu_reg = 5'(10 + i); lu_data = 32'hA0 + 32'(i);
      tick();
    end
    lu_valid = 1'b0;
    check("t4.count4", 32'(fifo_count), 32'd4);
    check("t4.lu_ready", 32'(lu_ready), 32'd0);
    check("t4.stall", 32'(alu_stall), 32'd1);
    tick();
    check_wr("t4.drain10", 1'b1, 5'd10, 32'hA0);
    check("t4.count3", 32'(fifo_count), 32'd3);
    check("t4.stall_drop", 32'(alu_stall), 32'd0);
    tick();
    check_wr("t4.alu7", 1'b1, 5'd7, 32'h99);
    check("t4.count3b", 32'(fifo_count), 32'd3);
    alu_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_wr($sformatf("t4.drain%0d", 10 + i), 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
    end
    check("t4.empty", 32'(fifo_count), 32'd0);

    // Same-cycle issue and retire of r9; ALU r0 writes act as idle
    iss_valid = 1'b1; iss_reg = 5'd9;
    tick();
    iss_valid = 1'b0;
    check("t5.pend9", pending, 32'h200);
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hBAD;
    lu_valid = 1'b1; lu_reg = 5'd9; lu_data = 32'h99;
    tick();
    lu_valid = 1'b0;
    check("t5.r0_idle", 32'(RegWrite), 32'd0);
    check("t5.count1", 32'(fifo_count), 32'd1);
    iss_valid = 1'b1; iss_reg = 5'd9;
    tick();
    iss_valid = 1'b0; alu_valid = 1'b0;
    check_wr("t5.pop9", 1'b1, 5'd9, 32'h99);
    check("t5.set_wins", pending, 32'h200);
    tick();
    check_wr("t5.idle_hold", 1'b0, 5'd9, 32'h99);

    // r0 long-unit transfer completes the handshake but is not queued
    lu_valid = 1'b1; lu_reg = 5'd0; lu_data = 32'h1;
    check("t6.ready_r0", 32'(lu_ready), 32'd1);
    tick();
    lu_valid = 1'b0;
    check("t6.count_r0", 32'(fifo_count), 32'd0);
    check("t6.no_write", 32'(RegWrite), 32'd0);

    // Reset mid-operation discards queued entries and pending bits
    alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 32'h2;
    iss_valid = 1'b1; iss_reg = 5'd20;
    lu_valid = 1'b1; lu_reg = 5'd21; lu_data = 32'h21;
    tick(); tick();
    iss_valid = 1'b0; lu_valid = 1'b0; alu_valid = 1'b0;
    check("t7.count2", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7.count_rst", 32'(fifo_count), 32'd0);
    check("t7.pend_rst", pending, 32'h0);
    check_wr("t7.wr_rst", 1'b0, 5'd0, 32'h0);
    tick();
    check("t7.no_stale", 32'(RegWrite), 32'd0);

`ifdef WB_FWD_EN
    alu_valid = 1'b1; alu_reg = 5'd12; alu_data = 32'h1234;
    tick();
    alu_valid = 1'b0;
    fwd_addr_1 = 5'd12; fwd_addr_2 = 5'd0;
    #1;
    check("fwd.hit1", 32'(fwd_hit_1), 32'd1);
    check("fwd.data1", fwd_data_1, 32'h1234);
    check("fwd.hit2", 32'(fwd_hit_2), 32'd0);
    check("fwd.data2", fwd_data_2, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
